// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS DIV/DIVU iterative divider.
package mips_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_ITER    = 32;
  // Edges from the start-sampling edge up to and including the edge entering DONE.
  localparam int DIV_LATENCY = 35;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } div_state_e;

  function automatic logic [DIV_WIDTH-1:0] neg32(input logic [DIV_WIDTH-1:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/adder_32.sv
// 32-bit adder/subtractor; in subtract mode carryout=1 means no borrow.
module adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] sum,
  output logic        carryout
);

  logic [32:0] full;

  assign full     = {1'b0, a} + {1'b0, b ^ {32{sub}}} + {32'd0, sub};
  assign sum      = full[31:0];
  assign carryout = full[32];

endmodule

// File: rtl/mips_div.sv
// Iterative restoring divider for MIPS DIV/DIVU: quotient -> LO, remainder -> HI.
//
// state | meaning
// IDLE  | waiting for start; operands latched when start is seen
// PREP  | form operand magnitudes, load iteration counter
// CALC  | one shift-subtract step per cycle until the counter expires
// FIX   | apply signs / divide-by-zero result, register outputs
// DONE  | results valid, done pulse
module mips_div
  import mips_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITER  = DIV_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(ITER + 1);

  div_state_e       state, state_nx;
  logic [CW-1:0]    cnt;
  logic             sgn_q;
  logic [WIDTH-1:0] dividend_q, divisor_q;
  logic [WIDTH-1:0] dvs_mag, rem, quo;
  logic [WIDTH-1:0] rem_sh, trial;
  logic             no_borrow, step_ok;
  logic             dz, q_neg, r_neg;
  logic [WIDTH-1:0] q_fix, r_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_PREP;
      S_PREP:  state_nx = S_CALC;
      S_CALC:  if (cnt <= CW'(1)) state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);

  assign rem_sh = {rem[WIDTH-2:0], quo[WIDTH-1]};

  adder_32 u_trial (
    .a        (rem_sh),
    .b        (dvs_mag),
    .sub      (1'b1),
    .sum      (trial),
    .carryout (no_borrow)
  );

  // A bit shifted out of rem means the 33-bit partial remainder exceeds any divisor.
  assign step_ok = no_borrow | rem[WIDTH-1];

  assign dz    = (divisor_q == '0);
  assign q_neg = sgn_q & (dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1]);
  assign r_neg = sgn_q & dividend_q[WIDTH-1];
  assign q_fix = dz ? '1 : (q_neg ? neg32(quo) : quo);
  assign r_fix = dz ? dividend_q : (r_neg ? neg32(rem) : rem);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sgn_q      <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      dvs_mag    <= '0;
      rem        <= '0;
      quo        <= '0;
      quotient   <= '0;
      remainder  <= '0;
      div_zero   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sgn_q      <= is_signed;
            dividend_q <= dividend;
            divisor_q  <= divisor;
          end
        end
        S_PREP: begin
          rem     <= '0;
          quo     <= (sgn_q && dividend_q[WIDTH-1]) ? neg32(dividend_q) : dividend_q;
          dvs_mag <= (sgn_q && divisor_q[WIDTH-1]) ? neg32(divisor_q) : divisor_q;
          cnt     <= CW'(ITER);
        end
        S_CALC: begin
          if (cnt != '0) begin
            rem <= step_ok ? trial : rem_sh;
            quo <= {quo[WIDTH-2:0], step_ok};
            cnt <= cnt - CW'(1);
          end
        end
        S_FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          div_zero  <= dz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div.sv
// Randomized self-checking bench for mips_div against a plain-arithmetic reference.
module tb_mips_div;

  // Edge on which done is first seen, counted after the start-sampling edge
  // (the sampling edge itself is the first of the 35).
  localparam int DONE_EDGE = 34;
  localparam int WINDOW    = 40;

  logic        clk, rst, start, is_signed;
  logic [31:0] dividend, divisor, quotient, remainder;
  logic        busy, done, div_zero;

  int n_checks = 0;
  int n_errs   = 0;
  logic [31:0] prev_q, prev_r;
  logic        prev_dz;

  mips_div #(.WIDTH(32), .ITER(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb;
    dz = (b == 32'd0);
    if (dz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // mode 0: plain; 1: second start 5 edges in; 2: start held during the DONE cycle
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int mode, input string tag);
    logic [31:0] eq, er;
    logic        edz;
    int          first_done, ndone;
    ref_div(sgn, a, b, eq, er, edz);
    is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
    chk({tag, ".busy_on"}, {31'd0, busy}, 32'd1);
    first_done = -1;
    ndone = 0;
    for (int n = 1; n <= WINDOW; n++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = n;
      end
      if (n == DONE_EDGE - 1) begin
        chk({tag, ".busy_pre"}, {31'd0, busy}, 32'd1);
        chk({tag, ".q_hold"}, quotient, prev_q);
      end
      if (n == DONE_EDGE) begin
        chk({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, ".quotient"}, quotient, eq);
        chk({tag, ".remainder"}, remainder, er);
        chk({tag, ".div_zero"}, {31'd0, div_zero}, {31'd0, edz});
      end
      if (n == DONE_EDGE + 2) begin
        chk({tag, ".busy_after"}, {31'd0, busy}, 32'd0);
        chk({tag, ".r_hold"}, remainder, er);
      end
      start = ((mode == 1) && (n == 4)) || ((mode == 2) && done);
      if (start) begin
        dividend = $urandom; divisor = $urandom_range(1, 9);
      end
    end
    start = 1'b0;
    chk({tag, ".done_edge"}, 32'(first_done), 32'(DONE_EDGE));
    chk({tag, ".done_count"}, 32'(ndone), 32'd1);
    prev_q = eq; prev_r = er; prev_dz = edz;
  endtask

  initial begin
    logic        sgn;
    logic [31:0] a, b;
    int          sel, ndone;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    prev_q = '0; prev_r = '0; prev_dz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.div_zero", {31'd0, div_zero}, 32'd0);
    chk("rst.quotient", quotient, 32'd0);
    chk("rst.remainder", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, 0, "u100_7");
    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, "s-7_2");
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, "s7_-2");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "s_ovf");
    run_op(1'b0, 32'h1234_5678, 32'd0, 0, "u_dz");
    run_op(1'b1, 32'hF000_0001, 32'd0, 0, "s_dz");
    run_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 0, "u_bigdiv");
    run_op(1'b0, 32'd5000, 32'd13, 1, "restart");
    run_op(1'b1, 32'hFFFF_FC18, 32'd9, 2, "start_in_done");

    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 32'd0;
      else if (sel < 5)  b = $urandom_range(1, 20);
      else               b = $urandom;
      if (sel < 5 && sgn && $urandom_range(0, 1) == 1) b = -b;
      run_op(sgn, a, b, $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    // Abort mid-operation with an asynchronous reset.
    dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.done", {31'd0, done}, 32'd0);
    chk("abort.quotient", quotient, 32'd0);
    chk("abort.remainder", remainder, 32'd0);
    chk("abort.div_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < WINDOW; n++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort.no_done", 32'(ndone), 32'd0);
    prev_q = '0; prev_r = '0; prev_dz = 1'b0;
    run_op(1'b0, 32'd30, 32'd4, 0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/mips_div.md
MIPS_DIV -- requirements
Module: mips_div

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 Parameter ITER, default 32, number of iteration cycles; it SHALL equal WIDTH.
REQ-003 clk  input  1  rising-edge clock; one clock domain.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request pulse; it SHALL be sampled only in IDLE.
REQ-006 is_signed  input  1  1=DIV (two's complement), 0=DIVU; latched with start.
REQ-007 dividend  input  32  numerator; latched with start.
REQ-008 divisor  input  32  denominator; latched with start.
REQ-009 busy  output  1  high from the edge after start is accepted until done is asserted.
REQ-010 done  output  1  single-cycle pulse when results are valid.
REQ-011 quotient  output  32  result for LO.
REQ-012 remainder  output  32  result for HI.
REQ-013 div_zero  output  1  divisor was zero for the last completed operation.

Function
REQ-014 The FSM SHALL have states IDLE, PREP, CALC, FIX and DONE.
- IDLE->PREP on start.
- PREP->CALC after 1 cycle.
- CALC->FIX after ITER cycles.
- FIX->DONE after 1 cycle.
- DONE->IDLE after 1 cycle.
REQ-015 PREP SHALL form operand magnitudes: two's-complement negation when is_signed=1 and the sign bit is set; raw values otherwise.
REQ-016 CALC SHALL perform one restoring shift-subtract step per cycle:
- shift {rem,quo} left by 1;
- trial = rem - |divisor|;
- if trial is non-negative (borrow-free), rem=trial and quo LSB=1;
- otherwise quo LSB=0.
REQ-017 The iteration counter SHALL count ITER down to 0 and SHALL NOT wrap.
REQ-018 FIX SHALL apply the signs when is_signed=1:
- quotient negated when the dividend and divisor signs differ;
- remainder negated when the dividend is negative;
- quotient truncates toward zero.
REQ-019 done SHALL be high exactly in the DONE cycle, which is the 35th cycle after the edge that sampled start (latency 35 edges).
REQ-020 quotient, remainder and div_zero SHALL update only on the edge entering DONE and SHALL hold until the next DONE.
REQ-021 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-022 start asserted in the DONE cycle SHALL be ignored; start is accepted again once the FSM is in IDLE.
REQ-023 A divisor of zero SHALL still take the full latency and produce:
- quotient 0xFFFFFFFF;
- remainder equal to the dividend;
- div_zero=1.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 with no flag.
REQ-025 Input changes while busy=1 SHALL NOT affect the result.

Reset
REQ-026 rst SHALL asynchronously force:
- state=IDLE;
- busy=0, done=0, div_zero=0;
- quotient=0, remainder=0;
- counter=0.
REQ-027 rst asserted mid-operation SHALL abort the operation; no done SHALL follow.
REQ-028 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-029 The state encodings, ITER and the latency constant (35) SHALL reside in the shared package mips_pkg.
REQ-030 The trial subtraction SHALL instantiate the existing adder_32 in subtract mode as the sole sub-module; its carryout SHALL serve as the no-borrow indication.

Verification
REQ-031 Unsigned 100/7 -> done at edge 35 after start; quotient=14, remainder=2, div_zero=0.
REQ-032 Signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
REQ-033 Signed 7/-2 -> quotient -3, remainder 1; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-034 Divide by zero, 0x12345678/0 -> quotient 0xFFFFFFFF, remainder 0x12345678, div_zero=1.
REQ-035 Second start 5 cycles into an operation with different operands -> ignored; the first operation's results are unchanged; exactly one done pulse.
REQ-036 rst pulsed at cycle 10 of an operation -> outputs zero, no done; the next start (30/4, unsigned) -> quotient 7, remainder 2.
